// File: rtl/time_manager.sv
// rtl/time_manager.sv - emulation-time arbiter: registered min tree plus step FSM; TIME_MANAGER_STATS_EN adds step_count/mono_err
module time_manager #(
  parameter int N      = 4,
  parameter int TIME_W = 32
) (
  input  logic                     i_clk_sys,
  input  logic                     i_rst_n,
  input  logic [N-1:0][TIME_W-1:0] i_time_clocks,
  input  logic                     i_run,
  input  logic                     i_stop_en,
  input  logic [TIME_W-1:0]        i_time_stop,
  output logic [TIME_W-1:0]        o_time_next,
  output logic                     o_issue,
  output logic                     o_stopped
`ifdef TIME_MANAGER_STATS_EN
  ,
  output logic [31:0]              o_step_count,
  output logic                     o_mono_err
`endif
);

  localparam int LAT = (N <= 1) ? 1 : $clog2(N);
  localparam int CW  = $clog2(LAT + 2);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(LAT + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Number of live nodes at tree level l (level 0 is the raw inputs)
  function automatic int lvl_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  // Flat index of the first node of tree level l
  function automatic int lvl_off(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += lvl_cnt(k);
    return s;
  endfunction

  localparam int NODES = lvl_off(LAT + 1);

  logic [TIME_W-1:0] w_node [NODES];
  logic [TIME_W-1:0] w_tree_min;

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign w_node[i] = i_time_clocks[i];
  end

  for (genvar l = 1; l <= LAT; l++) begin : g_lvl
    for (genvar j = 0; j < lvl_cnt(l); j++) begin : g_node
      localparam int SRC = lvl_off(l - 1) + 2 * j;
      localparam int DST = lvl_off(l) + j;
      logic [TIME_W-1:0] r_min;
      if (2 * j + 1 < lvl_cnt(l - 1)) begin : g_pair
        // Keep the smaller of the pair; on a tie the lower index wins
        always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
          if (!i_rst_n) r_min <= '1;
          else if (w_node[SRC+1] < w_node[SRC]) r_min <= w_node[SRC+1];
          else r_min <= w_node[SRC];
        end
      end else begin : g_pass
        // Odd leftover is delayed one level so every path has LAT registers
        always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
          if (!i_rst_n) r_min <= '1;
          else r_min <= w_node[SRC];
        end
      end
      assign w_node[DST] = r_min;
    end
  end

  assign w_tree_min = w_node[NODES-1];

  typedef enum logic [1:0] {WAIT, ISSUE, STOP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_load;
  logic [TIME_W-1:0] r_time_next;
  logic              r_issue;

  // Next state: the edge that would take the wait counter to zero is the
  // decision edge, which gives a LAT+2 cycle step period
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      WAIT: begin
        if (r_cnt > CNT_ONE) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (i_run) begin
          w_state_nxt = ISSUE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ISSUE: begin
        if (i_stop_en && (w_tree_min >= i_time_stop)) begin
          w_state_nxt = STOP;
        end else if (w_tree_min == '1) begin
          // Reserved value: never broadcast, retry after one cycle
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_RELOAD;
          w_load      = 1'b1;
        end
      end
      STOP: begin
        w_state_nxt = STOP;
      end
      default: begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = CNT_RELOAD;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= WAIT;
    else r_state <= w_state_nxt;
  end

  // Wait counter, broadcast time and one-cycle issue pulse
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= CNT_RELOAD;
      r_time_next <= '1;
      r_issue     <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_issue <= w_load;
      if (w_load) r_time_next <= w_tree_min;
    end
  end

  assign o_time_next = r_time_next;
  assign o_issue     = r_issue;
  assign o_stopped   = (r_state == STOP);

`ifdef TIME_MANAGER_STATS_EN
  logic [31:0] r_step_count;
  logic        r_mono_err;
  logic        r_loaded;

  // Count loads and flag any load that does not advance past the previous one
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_count <= '0;
      r_mono_err   <= 1'b0;
      r_loaded     <= 1'b0;
    end else if (w_load) begin
      r_step_count <= r_step_count + 32'd1;
      r_loaded     <= 1'b1;
      if (r_loaded && (w_tree_min <= r_time_next)) r_mono_err <= 1'b1;
    end
  end

  assign o_step_count = r_step_count;
  assign o_mono_err   = r_mono_err;
`endif

endmodule

// File: tb/tb_time_manager.sv
// tb/tb_time_manager.sv - directed self-checking bench for time_manager
module tb_time_manager;
  localparam int N   = 4;
  localparam int TW  = 32;
  localparam int PER = 4;
  localparam logic [TW-1:0] ALL1 = '1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0][TW-1:0] time_clocks;
  logic                 run = 1'b0;
  logic                 stop_en = 1'b0;
  logic [TW-1:0]        time_stop = '0;
  logic [TW-1:0]        time_next;
  logic                 issue;
  logic                 stopped;
`ifdef TIME_MANAGER_STATS_EN
  logic [31:0]          step_count;
  logic                 mono_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [TW-1:0] t_m   [N];
  logic [TW-1:0] inc_m [N];
  bit            pend  [N];
  int            fires [N];
  int            fires_now;
  int            cyc;

  time_manager #(.N(N), .TIME_W(TW)) dut (
    .i_clk_sys     (clk),
    .i_rst_n       (rst_n),
    .i_time_clocks (time_clocks),
    .i_run         (run),
    .i_stop_en     (stop_en),
    .i_time_stop   (time_stop),
    .o_time_next   (time_next),
    .o_issue       (issue),
    .o_stopped     (stopped)
`ifdef TIME_MANAGER_STATS_EN
    ,
    .o_step_count  (step_count),
    .o_mono_err    (mono_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic setup(input logic [TW-1:0] s0, s1, s2, s3,
                       input logic [TW-1:0] d0, d1, d2, d3);
    t_m[0] = s0; t_m[1] = s1; t_m[2] = s2; t_m[3] = s3;
    inc_m[0] = d0; inc_m[1] = d1; inc_m[2] = d2; inc_m[3] = d3;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      fires[i] = 0;
      time_clocks[i] = t_m[i];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) t_m[i] = t_m[i] + inc_m[i];
      pend[i] = 1'b0;
      time_clocks[i] = t_m[i];
    end
    fires_now = 0;
    for (int i = 0; i < N; i++) begin
      if (time_next == t_m[i]) begin
        pend[i] = 1'b1;
        fires[i]++;
        fires_now++;
      end
    end
  endtask

  task automatic test_reset();
    setup(5, 6, 7, 8, 1, 1, 1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (time_next !== ALL1) begin n_fail++; $display("FAIL reset_time_next: got %h expected %h", time_next, ALL1); end
    n_checks++; if (issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b expected 0", issue); end
    n_checks++; if (stopped !== 1'b0) begin n_fail++; $display("FAIL reset_stopped: got %b expected 0", stopped); end
`ifdef TIME_MANAGER_STATS_EN
    n_checks++; if (step_count !== 32'd0) begin n_fail++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
    n_checks++; if (mono_err !== 1'b0) begin n_fail++; $display("FAIL reset_mono_err: got %b expected 0", mono_err); end
`endif
  endtask

  task automatic test_basic();
    setup(40, 10, 30, 20, 0, 0, 0, 0);
    run = 1'b1;
    stop_en = 1'b0;
    apply_reset();
    repeat (5) begin
      tick();
      if (cyc == 3) begin
        n_checks++; if (time_next !== ALL1) begin n_fail++; $display("FAIL basic_pre_value: got %h expected %h", time_next, ALL1); end
        n_checks++; if (issue !== 1'b0) begin n_fail++; $display("FAIL basic_pre_issue: got %b expected 0", issue); end
      end
      if (cyc == 4) begin
        n_checks++; if (time_next !== 32'd10) begin n_fail++; $display("FAIL basic_first_value: got %0d expected 10", time_next); end
        n_checks++; if (issue !== 1'b1) begin n_fail++; $display("FAIL basic_first_issue: got %b expected 1", issue); end
      end
      if (cyc == 5) begin
        n_checks++; if (issue !== 1'b0) begin n_fail++; $display("FAIL basic_issue_width: got %b expected 0", issue); end
        n_checks++; if (time_next !== 32'd10) begin n_fail++; $display("FAIL basic_hold_value: got %0d expected 10", time_next); end
      end
    end
  endtask

  task automatic test_stepping();
    logic [TW-1:0] exp_tab [8];
    int n_iss;
    int last;
    exp_tab = '{0, 2, 3, 4, 5, 6, 7, 8};
    n_iss = 0;
    last = 0;
    setup(0, 0, 0, 0, 7, 5, 3, 2);
    run = 1'b1;
    stop_en = 1'b0;
    apply_reset();
    while (n_iss < 8 && cyc < 80) begin
      tick();
      if (issue) begin
        n_checks++; if (time_next !== exp_tab[n_iss]) begin n_fail++; $display("FAIL step_value[%0d]: got %0d expected %0d", n_iss, time_next, exp_tab[n_iss]); end
        n_checks++;
        if (n_iss == 0) begin
          if (cyc != PER) begin n_fail++; $display("FAIL step_first_cycle: got %0d expected %0d", cyc, PER); end
        end else if (cyc - last != PER) begin
          n_fail++; $display("FAIL step_period[%0d]: got %0d expected %0d", n_iss, cyc - last, PER);
        end
        last = cyc;
        n_iss++;
      end
    end
    n_checks++; if (n_iss != 8) begin n_fail++; $display("FAIL step_count_timeout: got %0d issues expected 8", n_iss); end
    n_checks++; if (fires[0] != 2) begin n_fail++; $display("FAIL step_fires0: got %0d expected 2", fires[0]); end
    n_checks++; if (fires[1] != 2) begin n_fail++; $display("FAIL step_fires1: got %0d expected 2", fires[1]); end
    n_checks++; if (fires[2] != 3) begin n_fail++; $display("FAIL step_fires2: got %0d expected 3", fires[2]); end
    n_checks++; if (fires[3] != 5) begin n_fail++; $display("FAIL step_fires3: got %0d expected 5", fires[3]); end
`ifdef TIME_MANAGER_STATS_EN
    n_checks++; if (step_count !== 32'd8) begin n_fail++; $display("FAIL step_stat_count: got %0d expected 8", step_count); end
    n_checks++; if (mono_err !== 1'b0) begin n_fail++; $display("FAIL step_mono_err: got %b expected 0", mono_err); end
`endif
  endtask

  task automatic test_tie();
    int n_iss;
    n_iss = 0;
    setup(25, 25, 30, 25, 100, 100, 100, 100);
    run = 1'b1;
    stop_en = 1'b0;
    apply_reset();
    while (n_iss < 2 && cyc < 30) begin
      tick();
      if (issue) begin
        if (n_iss == 0) begin
          n_checks++; if (time_next !== 32'd25) begin n_fail++; $display("FAIL tie_value: got %0d expected 25", time_next); end
          n_checks++; if (fires_now != 3) begin n_fail++; $display("FAIL tie_fire_count: got %0d expected 3", fires_now); end
          n_checks++; if (pend[2] !== 1'b0) begin n_fail++; $display("FAIL tie_untied_fired: got %b expected 0", pend[2]); end
        end else begin
          n_checks++; if (time_next !== 32'd30) begin n_fail++; $display("FAIL tie_next_value: got %0d expected 30", time_next); end
          n_checks++; if (fires_now != 1) begin n_fail++; $display("FAIL tie_next_fires: got %0d expected 1", fires_now); end
        end
        n_iss++;
      end
    end
    n_checks++; if (n_iss != 2) begin n_fail++; $display("FAIL tie_timeout: got %0d issues expected 2", n_iss); end
  endtask

  task automatic test_run_gating();
    int n_iss;
    int n_bad;
    int start;
    bit seen;
    n_iss = 0;
    n_bad = 0;
    seen = 1'b0;
    setup(50, 60, 70, 80, 1, 1, 1, 1);
    run = 1'b0;
    stop_en = 1'b0;
    apply_reset();
    repeat (50) begin
      tick();
      if (issue) n_iss++;
      if (time_next !== ALL1) n_bad++;
    end
    n_checks++; if (n_iss != 0) begin n_fail++; $display("FAIL gate_issues: got %0d expected 0", n_iss); end
    n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL gate_time_next: got %0d non-idle cycles expected 0", n_bad); end
    run = 1'b1;
    start = cyc;
    while (!seen && cyc - start < 10) begin
      tick();
      if (issue) begin
        seen = 1'b1;
        n_checks++; if (cyc - start != 2) begin n_fail++; $display("FAIL gate_release_latency: got %0d expected 2", cyc - start); end
        n_checks++; if (time_next !== 32'd50) begin n_fail++; $display("FAIL gate_release_value: got %0d expected 50", time_next); end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL gate_release_timeout: got no issue expected one"); end
  endtask

  task automatic test_stop();
    logic [TW-1:0] exp_tab [4];
    int n_iss;
    int last;
    int stop_cyc;
    exp_tab = '{0, 30, 60, 90};
    n_iss = 0;
    last = 0;
    stop_cyc = -1;
    setup(0, 0, 0, 0, 30, 30, 30, 30);
    run = 1'b1;
    stop_en = 1'b1;
    time_stop = 32'd100;
    apply_reset();
    repeat (40) begin
      tick();
      if (issue) begin
        if (n_iss < 4) begin
          n_checks++; if (time_next !== exp_tab[n_iss]) begin n_fail++; $display("FAIL stop_value[%0d]: got %0d expected %0d", n_iss, time_next, exp_tab[n_iss]); end
        end
        last = cyc;
        n_iss++;
      end
      if (stopped && stop_cyc < 0) stop_cyc = cyc;
    end
    n_checks++; if (n_iss != 4) begin n_fail++; $display("FAIL stop_issue_count: got %0d expected 4", n_iss); end
    n_checks++; if (stopped !== 1'b1) begin n_fail++; $display("FAIL stop_flag: got %b expected 1", stopped); end
    n_checks++; if (time_next !== 32'd90) begin n_fail++; $display("FAIL stop_hold: got %0d expected 90", time_next); end
    n_checks++; if (stop_cyc - last != PER) begin n_fail++; $display("FAIL stop_rise_cycle: got %0d expected %0d", stop_cyc - last, PER); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (stopped !== 1'b0) begin n_fail++; $display("FAIL stop_async_clear: got %b expected 0", stopped); end
    n_checks++; if (time_next !== ALL1) begin n_fail++; $display("FAIL stop_async_time: got %h expected %h", time_next, ALL1); end
    stop_en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    setup(0, 0, 0, 0, 30, 30, 30, 30);
    run = 1'b1;
    stop_en = 1'b0;
    apply_reset();
    while (!found && cyc < 40) begin
      tick();
      if (issue && time_next == 32'd60) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL areset_setup: got no issue of 60 expected one"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (time_next !== ALL1) begin n_fail++; $display("FAIL areset_time_next: got %h expected %h", time_next, ALL1); end
    n_checks++; if (issue !== 1'b0) begin n_fail++; $display("FAIL areset_issue: got %b expected 0", issue); end
    n_checks++; if (stopped !== 1'b0) begin n_fail++; $display("FAIL areset_stopped: got %b expected 0", stopped); end
`ifdef TIME_MANAGER_STATS_EN
    n_checks++; if (step_count !== 32'd0) begin n_fail++; $display("FAIL areset_step_count: got %0d expected 0", step_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stepping();
    test_tie();
    test_run_gating();
    test_stop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
